rx_packet_sequencer: RTL
========================

# rx_packet_sequencer

Receive-side packet sequencer for the serial bit receiver. It hunts for the sync pattern and removes stuffed bits. It drives the per-byte bit counter (0..7) and the packet byte counter, and assembles LSB-first bytes. It frames packets on end-of-packet and reports alignment, stuffing and length errors. It sits between the bit decoder (which supplies bit strobes and EOP) and the receive FIFO (which consumes bytes).

## Interface
- SYNC_BYTE, 8'h80: sync pattern as it appears in the shift register after 8 bits (wire order 0,0,0,0,0,0,0,1).
- MAX_BYTES, 25: maximum data bytes per packet, 1..31.

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- bit_strobe  in  1  one-cycle pulse, new decoded bit on bit_in.
- bit_in  in  1  decoded bit value, sampled only when bit_strobe=1.
- eop  in  1  one-cycle end-of-packet pulse.
- rx_data  out  8  last completed byte, LSB received first.
- byte_valid  out  1  one-cycle pulse, rx_data is new.
- bit_count  out  3  accepted data bits in the current byte.
- byte_count  out  5  completed bytes in the current packet.
- receiving  out  1  high in DATA and STUFF.
- pkt_done  out  1  one-cycle pulse, packet ended cleanly.
- rx_error  out  1  level, set on entering ERROR.

## Operation
- The shift register is 8 bits. On every bit_strobe it shifts right and bit_in enters bit 7. It shifts in every state except for a discarded stuffed bit.
- States: IDLE, DATA, STUFF, ERROR.
- IDLE: sliding sync hunt, compared only on bit_strobe cycles.
  - When the post-shift value equals SYNC_BYTE, go to DATA.
  - On sync detect, clear bit_count, byte_count, ones_run and rx_error.
  - eop is ignored in IDLE.
- DATA: each strobed bit is accepted.
  - bit_count increments and wraps 7 to 0.
  - ones_run (0..6) increments on a 1 and clears on a 0. ones_run carries across byte boundaries.
  - If an accepted 1 makes ones_run reach 6, go to STUFF.
- Byte completion occurs on the strobe that accepts the bit with bit_count=7.
  - If byte_count < MAX_BYTES: rx_data takes the post-shift value, byte_valid pulses, and byte_count increments.
  - If byte_count = MAX_BYTES: go to ERROR, with no byte_valid and byte_count unchanged.
  - A byte can complete on the same strobe that enters STUFF; both actions happen.
- STUFF: the next strobed bit is the stuff bit.
  - A 0 is discarded (no shift, bit_count unchanged), ones_run clears, and the state returns to DATA.
  - A 1 goes to ERROR.
- eop in DATA:
  - If bit_count=0 and byte_count ≥ 1: pkt_done pulses and the state goes to IDLE.
  - Otherwise go to ERROR.
- eop in STUFF goes to ERROR.
- eop has priority over bit_strobe in the same cycle. That bit is dropped, not shifted and not counted.
- ERROR: all bits are ignored; eop goes to IDLE. rx_error stays high until the next sync detect or reset.
- bit_count and byte_count hold their values after a packet ends, until the next sync detect.
- rx_data holds until the next completed byte.

## Timing
- All outputs are registered.
- Reset values: state IDLE, shift register 8'h00, rx_data 8'h00, and all other outputs 0.
- Reset mid-packet takes effect asynchronously. No byte_valid or pkt_done is produced for the partial packet.
- byte_valid is high exactly in the cycle after the completing bit_strobe. rx_data is valid in that same cycle.
- pkt_done is high in the cycle after eop. The last byte_valid of the packet precedes pkt_done by at least one cycle.
- rx_error rises in the cycle after the erroring strobe or eop.
- bit_count and byte_count update in the cycle after the strobe.
- bit_strobe may arrive back-to-back on every cycle. No bits are lost except the defined drops (stuff bit, eop collision).

## Test plan
- Clean packet: drive sync bits 0,0,0,0,0,0,0,1, then data bits 1,0,1,0,0,1,0,1, then eop.
  - Expect byte_valid once with rx_data=8'hA5 and byte_count=1, then pkt_done one cycle after eop, then IDLE.
- Stuffing: send data 8'hFF with a 0 inserted after the sixth 1.
  - Expect rx_data=8'hFF, bit_count back to 0, and no extra bit counted.
  - Repeat with the stuff bit = 1: expect rx_error=1 and no byte_valid.
- Misaligned EOP: sync, 3 data bits, eop.
  - Expect rx_error=1, no pkt_done, and state returns to IDLE.
  - Then a new sync detect must clear rx_error.
- Overflow: MAX_BYTES=25, send 26 bytes.
  - Expect 25 byte_valid pulses, byte_count=25, and rx_error on the 26th byte.
  - The following eop produces no pkt_done.
- Collision and reset: assert eop and bit_strobe in the same cycle at bit_count=0 after 2 bytes.
  - Expect pkt_done and the bit dropped.
  - Separately, assert rst mid-byte: expect all outputs 0 immediately and IDLE.

Source files
------------

// File: rtl/rx_packet_sequencer.sv
// ============================================================================
//  Module      : rx_packet_sequencer
//  Description : Receive-side sync hunt, bit destuffing, LSB-first byte
//                assembly and packet framing with error reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_packet_sequencer #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_strobe,
    input  logic       bit_in,
    input  logic       eop,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic [2:0] bit_count,
    output logic [4:0] byte_count,
    output logic       receiving,
    output logic       pkt_done,
    output logic       rx_error
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_data  = 2'd1;
    localparam logic [1:0] c_st_stuff = 2'd2;
    localparam logic [1:0] c_st_error = 2'd3;

    localparam logic [4:0] c_max_bytes = 5'(MAX_BYTES);

    logic [1:0] r_state;
    // Bit 0 of the 8-bit shift register is never observed before it is
    // shifted out, so only bits 7:1 are held.
    logic [6:0] r_shift_hi;
    logic [2:0] r_ones;

    logic [7:0] w_shifted;
    logic [1:0] w_state_nxt;
    logic [6:0] w_shift_hi_nxt;
    logic [2:0] w_ones_nxt;
    logic [2:0] w_bit_cnt_nxt;
    logic [4:0] w_byte_cnt_nxt;
    logic [7:0] w_rx_data_nxt;
    logic       w_byte_valid_nxt;
    logic       w_pkt_done_nxt;
    logic       w_rx_error_nxt;
    logic       w_receiving_nxt;

    assign w_shifted = {bit_in, r_shift_hi};

    always_comb begin
        w_state_nxt      = r_state;
        w_shift_hi_nxt   = r_shift_hi;
        w_ones_nxt       = r_ones;
        w_bit_cnt_nxt    = bit_count;
        w_byte_cnt_nxt   = byte_count;
        w_rx_data_nxt    = rx_data;
        w_byte_valid_nxt = 1'b0;
        w_pkt_done_nxt   = 1'b0;
        w_rx_error_nxt   = rx_error;

        case (r_state)
            c_st_idle: begin
                if (bit_strobe) begin
                    w_shift_hi_nxt = w_shifted[7:1];
                    if (w_shifted == SYNC_BYTE) begin
                        w_state_nxt    = c_st_data;
                        w_bit_cnt_nxt  = 3'd0;
                        w_byte_cnt_nxt = 5'd0;
                        w_ones_nxt     = 3'd0;
                        w_rx_error_nxt = 1'b0;
                    end
                end
            end
            c_st_data: begin
                if (eop) begin
                    if ((bit_count == 3'd0) && (byte_count != 5'd0)) begin
                        w_pkt_done_nxt = 1'b1;
                        w_state_nxt    = c_st_idle;
                    end else begin
                        w_state_nxt    = c_st_error;
                        w_rx_error_nxt = 1'b1;
                    end
                end else if (bit_strobe) begin
                    w_shift_hi_nxt = w_shifted[7:1];
                    w_bit_cnt_nxt  = bit_count + 3'd1;
                    if (bit_in) begin
                        w_ones_nxt = r_ones + 3'd1;
                        if (r_ones == 3'd5) begin
                            w_state_nxt = c_st_stuff;
                        end
                    end else begin
                        w_ones_nxt = 3'd0;
                    end
                    // Overflow overrides a simultaneous entry into STUFF.
                    if (bit_count == 3'd7) begin
                        if (byte_count < c_max_bytes) begin
                            w_rx_data_nxt    = w_shifted;
                            w_byte_valid_nxt = 1'b1;
                            w_byte_cnt_nxt   = byte_count + 5'd1;
                        end else begin
                            w_state_nxt    = c_st_error;
                            w_rx_error_nxt = 1'b1;
                        end
                    end
                end
            end
            c_st_stuff: begin
                if (eop) begin
                    w_state_nxt    = c_st_error;
                    w_rx_error_nxt = 1'b1;
                end else if (bit_strobe) begin
                    if (!bit_in) begin
                        w_ones_nxt  = 3'd0;
                        w_state_nxt = c_st_data;
                    end else begin
                        w_shift_hi_nxt = w_shifted[7:1];
                        w_state_nxt    = c_st_error;
                        w_rx_error_nxt = 1'b1;
                    end
                end
            end
            default: begin
                if (eop) begin
                    w_state_nxt = c_st_idle;
                end else if (bit_strobe) begin
                    w_shift_hi_nxt = w_shifted[7:1];
                end
            end
        endcase

        w_receiving_nxt = (w_state_nxt == c_st_data) || (w_state_nxt == c_st_stuff);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_shift_hi <= 7'd0;
            r_ones     <= 3'd0;
            rx_data    <= 8'h00;
            byte_valid <= 1'b0;
            bit_count  <= 3'd0;
            byte_count <= 5'd0;
            receiving  <= 1'b0;
            pkt_done   <= 1'b0;
            rx_error   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift_hi <= w_shift_hi_nxt;
            r_ones     <= w_ones_nxt;
            rx_data    <= w_rx_data_nxt;
            byte_valid <= w_byte_valid_nxt;
            bit_count  <= w_bit_cnt_nxt;
            byte_count <= w_byte_cnt_nxt;
            receiving  <= w_receiving_nxt;
            pkt_done   <= w_pkt_done_nxt;
            rx_error   <= w_rx_error_nxt;
        end
    end

endmodule

`default_nettype wire
